// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens, word classification/decoding helpers and the
// alignment FSM state type shared by the TMDS transmit and receive paths.
package tmds_pkg;

   localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
   localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
   localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
   localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_SLIP,
      ST_WAIT,
      ST_LOCKED
   } tmds_state_e;

   function automatic logic tmds_is_ctrl(input logic [9:0] q);
      return q inside {TMDS_CTRL_00, TMDS_CTRL_01, TMDS_CTRL_10, TMDS_CTRL_11};
   endfunction

   function automatic logic [1:0] tmds_ctrl_bits(input logic [9:0] q);
      return (q == TMDS_CTRL_01) ? 2'b01 :
             (q == TMDS_CTRL_10) ? 2'b10 :
             (q == TMDS_CTRL_11) ? 2'b11 : 2'b00;
   endfunction

   // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
   function automatic logic [7:0] tmds_decode_data(input logic [9:0] q);
      logic [7:0] d;
      logic [7:0] o;
      d = q[9] ? ~q[7:0] : q[7:0];
      o[0] = d[0];
      for (int i = 1; i < 8; i++)
         o[i] = q[8] ? d[i] ^ d[i-1] : ~(d[i] ^ d[i-1]);
      return o;
   endfunction

endpackage

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: word-aligns one TMDS lane via bitslip on control-token
// runs and decodes aligned words into DE, control bits and pixel data.
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int unsigned ALIGN_TOKENS  = 16,
   parameter int unsigned SEARCH_CYCLES = 4096,
   parameter int unsigned BITSLIP_WAIT  = 8,
   parameter int unsigned LOCK_TIMEOUT  = 4096
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] tmds_in,
   output logic       bitslip,
   output logic       aligned,
   output logic       video_de,
   output logic [1:0] video_ctrl,
   output logic [7:0] video_data
);

   localparam int RW = $clog2(ALIGN_TOKENS + 1);
   localparam int SW = $clog2(SEARCH_CYCLES + 1);
   localparam int WW = $clog2(BITSLIP_WAIT + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);

   tmds_state_e   state_q, state_d;
   logic [9:0]    s1_q;
   logic [RW-1:0] run_q, run_d;
   logic [SW-1:0] search_q, search_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          bitslip_q, bitslip_d;
   logic          aligned_q, aligned_d;
   logic          de_q, de_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic [7:0]    data_q, data_d;
   logic          tok, run_done, search_done, wait_done, tmo_done;

   assign tok         = tmds_is_ctrl(s1_q);
   assign run_done    = tok && run_q == RW'(ALIGN_TOKENS - 1);
   assign search_done = search_q == SW'(SEARCH_CYCLES - 1);
   assign wait_done   = wait_q == WW'(BITSLIP_WAIT - 1);
   assign tmo_done    = !tok && tmo_q == TW'(LOCK_TIMEOUT - 1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_SEARCH;
         s1_q      <= '0;
         run_q     <= '0;
         search_q  <= '0;
         wait_q    <= '0;
         tmo_q     <= '0;
         bitslip_q <= 1'b0;
         aligned_q <= 1'b0;
         de_q      <= 1'b0;
         ctrl_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         s1_q      <= tmds_in;
         run_q     <= run_d;
         search_q  <= search_d;
         wait_q    <= wait_d;
         tmo_q     <= tmo_d;
         bitslip_q <= bitslip_d;
         aligned_q <= aligned_d;
         de_q      <= de_d;
         ctrl_q    <= ctrl_d;
         data_q    <= data_d;
      end
   end

   // Lock is tested before the search timeout so a simultaneous finish locks.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SEARCH: state_d = run_done ? ST_LOCKED : search_done ? ST_SLIP : ST_SEARCH;
         ST_SLIP:   state_d = ST_WAIT;
         ST_WAIT:   state_d = wait_done ? ST_SEARCH : ST_WAIT;
         ST_LOCKED: state_d = tmo_done ? ST_SEARCH : ST_LOCKED;
         default:   state_d = ST_SEARCH;
      endcase
   end

   // Counters idle at zero outside their state, so every entry starts clean.
   always_comb begin
      run_d    = (state_q != ST_SEARCH || !tok) ? '0 :
                 (run_q == RW'(ALIGN_TOKENS)) ? run_q : run_q + RW'(1);
      search_d = (state_q != ST_SEARCH) ? '0 :
                 (search_q == SW'(SEARCH_CYCLES)) ? search_q : search_q + SW'(1);
      wait_d   = (state_q != ST_WAIT) ? '0 :
                 (wait_q == WW'(BITSLIP_WAIT)) ? wait_q : wait_q + WW'(1);
      tmo_d    = (state_q != ST_LOCKED || tok) ? '0 :
                 (tmo_q == TW'(LOCK_TIMEOUT)) ? tmo_q : tmo_q + TW'(1);
   end

   always_comb begin
      bitslip_d = state_d == ST_SLIP;
      aligned_d = state_d == ST_LOCKED;
      de_d      = aligned_d && !tok;
      ctrl_d    = !aligned_d ? 2'b00 : tok ? tmds_ctrl_bits(s1_q) : ctrl_q;
      data_d    = de_d ? tmds_decode_data(s1_q) : 8'h00;
   end

   assign bitslip    = bitslip_q;
   assign aligned    = aligned_q;
   assign video_de   = de_q;
   assign video_ctrl = ctrl_q;
   assign video_data = data_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed + randomized checks of alignment, bitslip
// timing, lock loss and decoding against a spec-level model.
module tb_tmds_channel_decoder;

   localparam int SC = 64;
   localparam int BW = 8;
   localparam int AT = 16;
   localparam int LT = 128;
   localparam int ROT = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] tmds_in = '0;
   logic       bitslip, aligned, video_de;
   logic [1:0] video_ctrl;
   logic [7:0] video_data;

   always #5 clock = ~clock;

   tmds_channel_decoder #(
      .ALIGN_TOKENS (AT),
      .SEARCH_CYCLES(SC),
      .BITSLIP_WAIT (BW),
      .LOCK_TIMEOUT (LT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .tmds_in   (tmds_in),
      .bitslip   (bitslip),
      .aligned   (aligned),
      .video_de  (video_de),
      .video_ctrl(video_ctrl),
      .video_data(video_data)
   );

   logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
   logic [7:0] dec_tab [1024];
   int         tests = 0;
   int         fails = 0;
   string      phase = "init";

   int         m_mode, m_run, m_srch, m_wt, m_tmo;
   logic [9:0] m_s1, cur_w, wv;
   logic       cur_r;
   logic       e_bs, e_al, e_de;
   logic [1:0] e_ctrl;
   logic [7:0] e_data;
   bit         q_bits [$];

   function automatic int tok_idx(input logic [9:0] w);
      for (int i = 0; i < 4; i++)
         if (w == toks[i]) return i;
      return -1;
   endfunction

   function automatic logic [9:0] rand_data();
      logic [9:0] w;
      do w = 10'($urandom); while (tok_idx(w) >= 0);
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s [%s]: observed %0h expected %0h", tag, phase, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_mode = 0; m_run = 0; m_srch = 0; m_wt = 0; m_tmo = 0; m_s1 = '0;
      e_bs = 0; e_al = 0; e_de = 0; e_ctrl = '0; e_data = '0;
   endtask

   // Mode 0 search, 1 slip, 2 wait, 3 locked; counts include the current cycle.
   task automatic m_step(input logic [9:0] w);
      int t;
      t = tok_idx(m_s1);
      case (m_mode)
         0: begin
            m_srch++;
            m_run = (t >= 0) ? m_run + 1 : 0;
            if (m_run >= AT) begin m_mode = 3; m_tmo = 0; end
            else if (m_srch >= SC) m_mode = 1;
         end
         1: begin m_mode = 2; m_wt = 0; end
         2: begin
            m_wt++;
            if (m_wt >= BW) begin m_mode = 0; m_run = 0; m_srch = 0; end
         end
         default: begin
            m_tmo = (t >= 0) ? 0 : m_tmo + 1;
            if (m_tmo >= LT) begin m_mode = 0; m_run = 0; m_srch = 0; end
         end
      endcase
      e_bs   = m_mode == 1;
      e_al   = m_mode == 3;
      e_de   = e_al && t < 0;
      e_ctrl = !e_al ? 2'b00 : (t >= 0) ? 2'(t) : e_ctrl;
      e_data = e_de ? dec_tab[m_s1] : 8'h00;
      m_s1   = w;
   endtask

   task automatic cyc(input logic [9:0] w, input logic r);
      @(posedge clock);
      #1;
      if (cur_r) m_reset(); else m_step(cur_w);
      cur_w = w; cur_r = r;
      reset = r; tmds_in = w;
      if (r) m_reset();
      @(negedge clock);
      check("bitslip", bitslip, e_bs);
      check("aligned", aligned, e_al);
      check("video_de", video_de, e_de);
      check("video_ctrl", video_ctrl, e_ctrl);
      check("video_data", video_data, e_data);
   endtask

   task automatic get_word(output logic [9:0] w);
      logic [9:0] t;
      while (q_bits.size() < 20) begin
         t = toks[$urandom_range(0, 3)];
         for (int i = 0; i < 10; i++) q_bits.push_back(t[i]);
      end
      for (int i = 0; i < 10; i++) w[i] = q_bits.pop_front();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, n, pulses, last, extra;
      // Reference decode table built by running the forward TMDS encoder.
      for (int b = 0; b < 256; b++)
         for (int x = 0; x < 2; x++)
            for (int v = 0; v < 2; v++) begin
               logic [7:0] dd, qm;
               dd = 8'(b);
               qm[0] = dd[0];
               for (int i = 1; i < 8; i++)
                  qm[i] = x[0] ? qm[i-1] ^ dd[i] : ~(qm[i-1] ^ dd[i]);
               dec_tab[{v[0], x[0], v[0] ? ~qm : qm}] = dd;
            end
      m_reset();
      cur_r = 1'b1; cur_w = '0;

      phase = "reset";
      repeat (5) cyc(10'($urandom), 1'b1);

      phase = "lock";
      for (int k = 0; k < 16; k++) cyc(toks[0], 1'b0);
      cyc(toks[0], 1'b0);
      check("lock_before_16th", aligned, 1'b0);
      cyc(toks[0], 1'b0);
      check("lock_rise", aligned, 1'b1);
      check("lock_ctrl", video_ctrl, 2'b00);
      check("lock_de", video_de, 1'b0);

      phase = "decode";
      cyc(10'h100, 1'b0);
      cyc(10'h200, 1'b0);
      cyc(toks[1], 1'b0);
      check("dec_100_de", video_de, 1'b1);
      check("dec_100_data", video_data, 8'h00);
      cyc(toks[0], 1'b0);
      check("dec_200_de", video_de, 1'b1);
      check("dec_200_data", video_data, 8'hFF);
      cyc(toks[0], 1'b0);
      check("dec_tok01_de", video_de, 1'b0);
      check("dec_tok01_ctrl", video_ctrl, 2'b01);

      phase = "rand_decode";
      for (int k = 0; k < 80; k++)
         cyc(($urandom_range(0, 7) == 0) ? toks[$urandom_range(0, 3)] : rand_data(), 1'b0);
      cyc(toks[$urandom_range(0, 3)], 1'b0);
      cyc(toks[$urandom_range(0, 3)], 1'b0);

      phase = "lock_loss";
      cnt = 0;
      for (int k = 0; k < 400 && aligned; k++) begin
         cyc(rand_data(), 1'b0);
         cnt++;
      end
      check("lock_loss_cycles", cnt, LT + 2);
      check("loss_de", video_de, 1'b0);
      check("loss_ctrl", video_ctrl, 2'b00);
      check("loss_data", video_data, 8'h00);
      n = 1;
      for (int k = 0; k < 300 && !bitslip; k++) begin
         cyc(rand_data(), 1'b0);
         n++;
      end
      check("loss_to_slip", n, SC + 1);

      phase = "reset_in_wait";
      cyc(rand_data(), 1'b0);
      cyc(rand_data(), 1'b0);
      cyc(rand_data(), 1'b1);
      cyc(rand_data(), 1'b1);
      cyc(rand_data(), 1'b0);
      n = 1;
      for (int k = 0; k < 300 && !bitslip; k++) begin
         cyc(rand_data(), 1'b0);
         n++;
      end
      check("wait_reset_to_slip", n, SC + 1);

      phase = "reset_mid_pulse";
      reset = 1'b1;
      #1;
      check("reset_mid_pulse", bitslip, 1'b0);
      cur_r = 1'b1;
      m_reset();
      cyc(rand_data(), 1'b1);
      cyc(rand_data(), 1'b1);

      phase = "slip_search";
      q_bits.delete();
      get_word(wv);
      q_bits.delete();
      get_word(wv);
      repeat (ROT) void'(q_bits.pop_front());
      get_word(wv);
      cyc(wv, 1'b0);
      n = 1; pulses = 0; last = 0;
      for (int k = 0; k < 2000 && !aligned; k++) begin
         if (bitslip) begin
            pulses++;
            if (pulses == 1) check("first_slip", n, SC + 1);
            else check("slip_period", n - last, SC + BW + 1);
            last = n;
            void'(q_bits.pop_front());
         end
         get_word(wv);
         cyc(wv, 1'b0);
         n++;
      end
      check("slip_locked", aligned, 1'b1);
      check("slip_count", pulses, (10 - ROT) % 10);
      extra = 0;
      for (int k = 0; k < 150; k++) begin
         get_word(wv);
         cyc(wv, 1'b0);
         if (bitslip) extra++;
      end
      check("no_slip_after_lock", extra, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side counterpart of the DVI transmit path. Accepts one TMDS lane as parallel 10-bit words from an `IDES10` deserializer clocked by the recovered pixel clock. Finds word alignment by driving the deserializer's bitslip input until control tokens appear consecutively. Decodes aligned words into pixel data, DE and the two control bits. Three instances (one per lane) sit behind the `IDES10`s and feed a video capture or timing block.

## Interface
- `ALIGN_TOKENS`, default 16: consecutive control tokens required to declare lock.
- `SEARCH_CYCLES`, default 4096: cycles spent searching at one slip position before slipping again.
- `BITSLIP_WAIT`, default 8: cycles the input is ignored after a bitslip pulse.
- `LOCK_TIMEOUT`, default 4096: cycles allowed in lock without any control token before lock is dropped.
- `clock` input, 1 bit: pixel clock; all logic on its rising edge. One clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `tmds_in` input, 10 bits: deserialized word; bit 0 is the first bit on the wire.
- `bitslip` output, 1 bit: one-cycle pulse to the `IDES10` `CALIB` input.
- `aligned` output, 1 bit: high while in LOCKED.
- `video_de` output, 1 bit: high when the word is a data word.
- `video_ctrl` output, 2 bits: {C1,C0} from the control token; holds its last value while DE is high.
- `video_data` output, 8 bits: decoded pixel byte; zero when DE is low.

## Operation
- Stage 1 registers `tmds_in` into `s1`. All classification and decoding use `s1`.
- Control tokens:
  - 10'b1101010100 → ctrl 00
  - 10'b0010101011 → ctrl 01
  - 10'b0101010100 → ctrl 10
  - 10'b1010101011 → ctrl 11
- Any other word is a data word.
- Data decode:
  - d = q[9] ? ~q[7:0] : q[7:0].
  - out[0] = d[0].
  - For i = 1..7: out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- FSM states: SEARCH, SLIP, WAIT, LOCKED. Reset state is SEARCH.
- SEARCH:
  - The run counter increments on each token in `s1`, of any token type; mixed types count as one run.
  - The run counter clears on any data word.
  - The run counter reaching `ALIGN_TOKENS` moves the FSM to LOCKED.
  - Otherwise the search counter reaching `SEARCH_CYCLES`-1 moves the FSM to SLIP.
  - Both counters clear on entry to SEARCH.
- SLIP: `bitslip`=1 for exactly this one cycle, then WAIT.
- WAIT: input is ignored for `BITSLIP_WAIT` cycles, then SEARCH.
- LOCKED:
  - A timeout counter clears on every token and increments on every data word.
  - Reaching `LOCK_TIMEOUT` moves the FSM to SEARCH, with both counters cleared.
  - LOCKED is left only by timeout or reset.
- If the run count completes and the search timeout expires on the same cycle, lock wins.
- Output gating: `video_de`, `video_ctrl` and `video_data` are forced to 0 on any cycle where `aligned`=0. Gating uses the next-state value, so outputs and `aligned` change on the same edge.

## Timing
- Reset values: `bitslip`=0, `aligned`=0, `video_de`=0, `video_ctrl`=0, `video_data`=0, `s1`=0, all counters 0.
- Latency: the word on `tmds_in` at edge n appears on the video outputs after edge n+2.
- `aligned` rises on the edge after the `ALIGN_TOKENS`-th consecutive token occupies `s1`.
- The first `bitslip` pulse occurs `SEARCH_CYCLES`+1 cycles after reset release with no tokens present.
- Slip period is `SEARCH_CYCLES`+`BITSLIP_WAIT`+1 cycles.
- Reset asserted in any state, including mid-pulse in SLIP, clears `bitslip` immediately with no completion of the pulse.
- Counter widths are $clog2(param+1). Counters saturate and never wrap.

## Structure
- Shared package `tmds_pkg` holds:
  - the four control token constants;
  - function `tmds_decode_data` (10→8 bits);
  - function `tmds_is_ctrl`;
  - the FSM state enum.
- The transmit encoder reuses the same token constants from `tmds_pkg`.
- No sub-module: FSM, counters and the two pipeline stages live in `tmds_channel_decoder`.

## Test plan
Bench uses `SEARCH_CYCLES`=64, `BITSLIP_WAIT`=8, `ALIGN_TOKENS`=16, `LOCK_TIMEOUT`=128.
- Reset: hold `reset` 5 cycles with random `tmds_in` → all outputs 0 throughout; no `bitslip`.
- Lock: drive 16 × 10'b1101010100 → `aligned` rises on the edge after the 16th word reaches `s1`; `video_ctrl`=00, `video_de`=0.
- Decode: while locked, drive 10'h100 then 10'h200 then 10'b0010101011 → two cycles later, in order:
  - `video_de`=1 with `video_data`=8'h00;
  - `video_de`=1 with `video_data`=8'hFF;
  - `video_de`=0 with `video_ctrl`=01.
- Slip search: token stream rotated by 3 bits, bench rotates by 1 bit per `bitslip` pulse → `bitslip` pulses are exactly 73 cycles apart; `aligned` rises after the slip count predicted by the model; no pulses after lock.
- Lock loss: while locked, drive 128 consecutive data words → `aligned` falls, all video outputs 0; next `bitslip` after a further 65 cycles of non-token input.
- Reset in WAIT: assert `reset` 3 cycles after a `bitslip` pulse → state returns to SEARCH with the search counter restarting from 0; the next pulse comes 65 cycles after release.
